// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer.
//   mode_e   : pattern select encoding (converge/diverge, walking one,
//              bar fill, blink).
//   seq_len  : number of steps in one full sequence for a given mode/width.
//   pattern  : LED vector for a given mode/step/width. Bits at or above
//              led_w are always 0. Any step outside the sequence decodes
//              to all off.
// LED widths up to LED_W_MAX are supported.
// -----------------------------------------------------------------------------
package led_seq_pkg;

    localparam int LED_W_MAX = 64;

    typedef enum logic [1:0] {
        MODE_CONV  = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_BAR   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    // Sequence length N(mode); step runs 0..N-1.
    function automatic int seq_len(input logic [1:0] mode, input int led_w);
        int n;
        case (mode)
            MODE_CONV:  n = led_w + 32'sd2;
            MODE_WALK:  n = led_w + 32'sd1;
            MODE_BAR:   n = led_w + 32'sd1;
            MODE_BLINK: n = 32'sd2;
            default:    n = 32'sd2;
        endcase
        return n;
    endfunction

    // Active-high LED pattern for one step.
    function automatic logic [LED_W_MAX-1:0] pattern(input logic [1:0] mode,
                                                     input int         step,
                                                     input int         led_w);
        logic [LED_W_MAX-1:0] p;
        int                   h;
        int                   k;
        p = '0;
        h = led_w / 32'sd2;
        // The diverging half (steps H+2..LED_W+1) mirrors the converging half,
        // so fold it onto an equivalent converging index k (0 means dark).
        if ((step >= 32'sd1) && (step <= h)) begin
            k = step;
        end else if ((step >= h + 32'sd2) && (step <= led_w + 32'sd1)) begin
            k = led_w + 32'sd2 - step;
        end else begin
            k = 32'sd0;
        end
        for (int i = 0; i < LED_W_MAX; i++) begin
            if (i < led_w) begin
                case (mode)
                    MODE_CONV:  p[i] = (k != 32'sd0) &&
                                       ((i == k - 32'sd1) || (i == led_w - k));
                    MODE_WALK:  p[i] = (step >= 32'sd1) && (step <= led_w) &&
                                       (i == step - 32'sd1);
                    MODE_BAR:   p[i] = (step >= 32'sd1) && (step <= led_w) &&
                                       (i < step);
                    MODE_BLINK: p[i] = (step == 32'sd1);
                    default:    p[i] = 1'b0;
                endcase
            end else begin
                p[i] = 1'b0;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Step-rate divider. A counter runs 0..TICK_DIV-1 and wraps; tick is a
// registered one-cycle pulse in the cycle after the counter reaches its last
// value, so ticks are TICK_DIV cycles apart and the first one arrives
// TICK_DIV cycles after en rises or reset releases.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   en    in  enable; while low the counter is held at 0 and tick is 0
//   tick  out one-cycle pulse per divider period
// -----------------------------------------------------------------------------
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 3500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next-state for the divider count and the tick pulse.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_seq.sv
// -----------------------------------------------------------------------------
// led_pattern_seq
// Parametrised LED pattern sequencer. A tick divider paces a step counter
// that advances while the lag-quality condition holds and falls back to
// step 0 otherwise. Four patterns are selectable; a sticky fault flag records
// a condition failure mid-sequence and seq_done pulses on every wrap.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   en        in  sequencer enable (low: step and led go dark next clock)
//   mode      in  pattern select (see led_seq_pkg::mode_e)
//   lag_xq    in  lag leading term, must be 0 for the condition to hold
//   lag_xh    in  lag trailing term, must be < THRESH (unsigned)
//   clr_fault in  synchronous fault clear (a simultaneous set wins)
//   led       out registered LED drive, one cycle behind step
//   step      out current step index
//   tick      out one-cycle pulse per divider period
//   seq_done  out one-cycle pulse when the sequence wraps to step 0
//   fault     out sticky condition-failure flag
// Build option:
//   LED_ACTIVE_LOW_EN - when defined, led is driven inverted (dark = all
//   ones, including the reset and disabled value) for sinking drivers.
// -----------------------------------------------------------------------------
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int                LED_W    = 8,
    parameter int                DATA_W   = 8,
    parameter int                TICK_DIV = 3500000,
    parameter logic [DATA_W-1:0] THRESH   = DATA_W'(8'h55)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [DATA_W-1:0]            lag_xq,
    input  logic [DATA_W-1:0]            lag_xh,
    input  logic                         clr_fault,
    output logic [LED_W-1:0]             led,
    output logic [$clog2(LED_W+2)-1:0]   step,
    output logic                         tick,
    output logic                         seq_done,
    output logic                         fault
);

    localparam int STEP_W = $clog2(LED_W + 2);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [LED_W-1:0] LED_OFF = {LED_W{1'b1}};
`else
    localparam logic [LED_W-1:0] LED_OFF = {LED_W{1'b0}};
`endif

    logic              tick_s;
    logic              ok_s;
    logic              last_s;
    logic              mode_chg_s;
    logic [LED_W-1:0]  pat_s;

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [1:0]        mode_q;
    logic [LED_W-1:0]  led_q;
    logic [LED_W-1:0]  led_d;
    logic              seq_done_q;
    logic              seq_done_d;
    logic              fault_q;
    logic              fault_d;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_s)
    );

    // Condition, wrap detect and pattern lookup. mode_q (not mode) is used
    // so that step and decode always refer to the same sequence length.
    always_comb begin
        ok_s       = (lag_xq == '0) && (lag_xh < THRESH);
        last_s     = (int'(step_q) == seq_len(mode_q, LED_W) - 32'sd1);
        mode_chg_s = (mode != mode_q);
        pat_s      = LED_W'(pattern(mode_q, int'(step_q), LED_W));
    end

    // Step counter, wrap pulse and fault flag next-state.
    always_comb begin
        step_d     = step_q;
        seq_done_d = 1'b0;
        if (clr_fault) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
        if (!en) begin
            step_d = '0;
        end else if (mode_chg_s) begin
            // Restart on a mode switch; a coincident tick is dropped so the
            // old step never runs past the new sequence length.
            step_d = '0;
        end else if (tick_s) begin
            if (ok_s) begin
                if (last_s) begin
                    step_d     = '0;
                    seq_done_d = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end else begin
                step_d = '0;
                // Set overrides a same-cycle clear.
                if (step_q != '0) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = fault_d;
                end
            end
        end else begin
            step_d = step_q;
        end
    end

    // LED drive next-state; polarity is applied by XOR with the dark value.
    always_comb begin
        if (!en) begin
            led_d = LED_OFF;
        end else begin
            led_d = pat_s ^ LED_OFF;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= '0;
            mode_q     <= 2'd0;
            led_q      <= LED_OFF;
            seq_done_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            step_q     <= step_d;
            mode_q     <= mode;
            led_q      <= led_d;
            seq_done_q <= seq_done_d;
            fault_q    <= fault_d;
        end
    end

    assign led      = led_q;
    assign step     = step_q;
    assign tick     = tick_s;
    assign seq_done = seq_done_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed testbench for led_pattern_seq: an 8-LED instance for most tests
// and a 4-LED instance for width scaling, both with a 4-cycle divider.
module tb_led_pattern_seq;

    localparam int TDIV = 4;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [7:0] OFF8 = 8'hFF;
    localparam logic [3:0] OFF4 = 4'hF;
`else
    localparam logic [7:0] OFF8 = 8'h00;
    localparam logic [3:0] OFF4 = 4'h0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] lag_xq;
    logic [7:0] lag_xh;
    logic       clr_fault;
    logic [7:0] led;
    logic [3:0] step;
    logic       tick;
    logic       seq_done;
    logic       fault;

    logic       en4;
    logic [1:0] mode4;
    logic       clr4;
    logic [3:0] led4;
    logic [2:0] step4;
    logic       tick4;
    logic       seq_done4;
    logic       fault4;

    int checks;
    int fails;

    logic [7:0] conv_tab [10] = '{8'h00, 8'h81, 8'h42, 8'h24, 8'h18,
                                  8'h00, 8'h18, 8'h24, 8'h42, 8'h81};
    logic [3:0] walk4_tab [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

    led_pattern_seq #(.LED_W(8), .DATA_W(8), .TICK_DIV(TDIV), .THRESH(8'h55)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .lag_xq(lag_xq),
        .lag_xh(lag_xh), .clr_fault(clr_fault), .led(led), .step(step),
        .tick(tick), .seq_done(seq_done), .fault(fault)
    );

    led_pattern_seq #(.LED_W(4), .DATA_W(8), .TICK_DIV(TDIV), .THRESH(8'h55)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .lag_xq(lag_xq),
        .lag_xh(lag_xh), .clr_fault(clr4), .led(led4), .step(step4),
        .tick(tick4), .seq_done(seq_done4), .fault(fault4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at the falling edge where the selected tick is high.
    task automatic wait_tick(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3 * TDIV + 4; c++) begin
            @(negedge clk);
            if ((sel ? tick4 : tick) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; fails++;
            $display("FAIL tick_timeout: tick stayed low, required a tick within %0d cycles", 3 * TDIV + 4);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; lag_xq = 8'h00; lag_xh = 8'h10;
        clr_fault = 1'b0; en4 = 1'b0; mode4 = 2'd1; clr4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== OFF8) begin fails++; $display("FAIL reset_led: got %h need %h", led, OFF8); end
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL reset_step: got %0d need 0", step); end
        checks++; if ({tick, seq_done, fault} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b need 000", {tick, seq_done, fault}); end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal;
        for (int i = 1; i <= 11; i++) begin
            wait_tick(1'b0);
            @(negedge clk);
            checks++; if (step !== 4'(i % 10)) begin fails++; $display("FAIL nom_step[%0d]: got %0d need %0d", i, step, i % 10); end
            checks++; if (seq_done !== (i == 10)) begin fails++; $display("FAIL nom_done[%0d]: got %b need %b", i, seq_done, (i == 10)); end
            @(negedge clk);
            checks++; if (led !== (conv_tab[i % 10] ^ OFF8)) begin fails++; $display("FAIL nom_led[%0d]: got %h need %h", i, led, conv_tab[i % 10] ^ OFF8); end
        end
    endtask

    task automatic test_cond_break;
        repeat (2) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd3) begin fails++; $display("FAIL brk_pre_step: got %0d need 3", step); end
        lag_xh = 8'h55;
        wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL brk_step: got %0d need 0", step); end
        checks++; if (fault !== 1'b1) begin fails++; $display("FAIL brk_fault: got %b need 1", fault); end
        @(negedge clk);
        checks++; if (led !== OFF8) begin fails++; $display("FAIL brk_led: got %h need %h", led, OFF8); end
        lag_xh = 8'h10;
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++; if (fault !== 1'b0) begin fails++; $display("FAIL brk_clear: got %b need 0", fault); end
    endtask

    task automatic test_set_clear;
        repeat (2) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd2) begin fails++; $display("FAIL sc_pre_step: got %0d need 2", step); end
        lag_xh = 8'h55;
        wait_tick(1'b0);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++; if (fault !== 1'b1) begin fails++; $display("FAIL sc_set_wins: got %b need 1", fault); end
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL sc_step: got %0d need 0", step); end
        lag_xh = 8'h10;
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        checks++; if (fault !== 1'b0) begin fails++; $display("FAIL sc_clear: got %b need 0", fault); end
    endtask

    task automatic test_mode_change;
        mode = 2'd2;
        @(negedge clk);
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL mc_bar_start: got %0d need 0", step); end
        repeat (5) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd5) begin fails++; $display("FAIL mc_bar_step: got %0d need 5", step); end
        mode = 2'd3;
        @(negedge clk);
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL mc_switch_step: got %0d need 0", step); end
        checks++; if (led !== (8'h1F ^ OFF8)) begin fails++; $display("FAIL mc_bar_led: got %h need %h", led, 8'h1F ^ OFF8); end
        @(negedge clk);
        checks++; if (led !== OFF8) begin fails++; $display("FAIL mc_switch_led: got %h need %h", led, OFF8); end
        for (int i = 1; i <= 4; i++) begin
            wait_tick(1'b0);
            @(negedge clk);
            checks++; if (step !== 4'(i % 2)) begin fails++; $display("FAIL mc_blink_step[%0d]: got %0d need %0d", i, step, i % 2); end
            checks++; if (seq_done !== (i % 2 == 0)) begin fails++; $display("FAIL mc_blink_done[%0d]: got %b need %b", i, seq_done, (i % 2 == 0)); end
            @(negedge clk);
            checks++; if (led !== (((i % 2) == 1 ? 8'hFF : 8'h00) ^ OFF8)) begin fails++; $display("FAIL mc_blink_led[%0d]: got %h need %h", i, led, ((i % 2) == 1 ? 8'hFF : 8'h00) ^ OFF8); end
        end
    endtask

    task automatic test_width4;
        en4 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_tick(1'b1);
            @(negedge clk);
            checks++; if (step4 !== 3'(i % 5)) begin fails++; $display("FAIL w4_step[%0d]: got %0d need %0d", i, step4, i % 5); end
            checks++; if (seq_done4 !== (i == 5)) begin fails++; $display("FAIL w4_done[%0d]: got %b need %b", i, seq_done4, (i == 5)); end
            @(negedge clk);
            checks++; if (led4 !== (walk4_tab[i % 5] ^ OFF4)) begin fails++; $display("FAIL w4_led[%0d]: got %h need %h", i, led4, walk4_tab[i % 5] ^ OFF4); end
        end
        en4 = 1'b0;
    endtask

    task automatic test_enable;
        wait_tick(1'b0);
        mode = 2'd0;
        @(negedge clk);
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL en_mode_step: got %0d need 0", step); end
        repeat (2) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd2) begin fails++; $display("FAIL en_pre_step: got %0d need 2", step); end
        lag_xh = 8'h55;
        wait_tick(1'b0);
        @(negedge clk);
        checks++; if (fault !== 1'b1) begin fails++; $display("FAIL en_fault_set: got %b need 1", fault); end
        lag_xh = 8'h10;
        repeat (4) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd4) begin fails++; $display("FAIL en_step4: got %0d need 4", step); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL en_off_step: got %0d need 0", step); end
        checks++; if (led !== OFF8) begin fails++; $display("FAIL en_off_led: got %h need %h", led, OFF8); end
        checks++; if (fault !== 1'b1) begin fails++; $display("FAIL en_off_fault: got %b need 1", fault); end
        repeat (2) @(negedge clk);
        checks++; if (tick !== 1'b0) begin fails++; $display("FAIL en_off_tick: got %b need 0", tick); end
        en = 1'b1;
    endtask

    task automatic test_reset_midseq;
        int n;
        repeat (2) wait_tick(1'b0);
        @(negedge clk);
        checks++; if (step !== 4'd2) begin fails++; $display("FAIL rst_pre_step: got %0d need 2", step); end
        rst_n = 1'b0;
        #1;
        checks++; if (step !== 4'd0) begin fails++; $display("FAIL rst_async_step: got %0d need 0", step); end
        checks++; if (led !== OFF8) begin fails++; $display("FAIL rst_async_led: got %h need %h", led, OFF8); end
        checks++; if ({tick, seq_done, fault} !== 3'b000) begin fails++; $display("FAIL rst_async_flags: got %b need 000", {tick, seq_done, fault}); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = c;
                break;
            end
        end
        checks++; if (n != TDIV) begin fails++; $display("FAIL rst_first_tick: got %0d cycles need %0d", n, TDIV); end
        @(negedge clk);
        checks++; if (step !== 4'd1) begin fails++; $display("FAIL rst_restart_step: got %0d need 1", step); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_nominal();
        test_cond_break();
        test_set_clear();
        test_mode_change();
        test_width4();
        test_enable();
        test_reset_midseq();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
